// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl -- machine-mode trap sequencer
//
// Sits between the EX stage, the CSR file and the fetch redirect logic.
// In IDLE it looks at the EX-stage instruction and decides whether to take
// a synchronous exception, execute an mret, or take a pending interrupt.
// Exceptions go straight to TRAP. Interrupts first wait in DRAIN for the
// pipeline to go idle. That wait is bounded by DRAIN_TO cycles, after which
// trap entry is forced and the sticky drain_to_o flag is raised. TRAP
// commands the CSR save. JUMP redirects fetch to the trap vector. RET
// restores the enable and redirects fetch to mepc.
//
// Optional build macro: TRAP_VECTORED_EN
//   When defined, and mtvec_i[1:0] == 2'b01, interrupts vector to
//   base + 4*code. Exceptions always go to base.
//   When undefined, the mode bits are ignored and every trap goes to base.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   ext/sft/tmr_irq_i                 level interrupt requests
//   meie/msie/mtie_i, glb_irq_i       per-source enables (mie), mstatus.MIE
//   exp_vld_i, exp_code_i             EX-stage exception and its cause code
//   mret_i                            EX-stage instruction is mret
//   pc_vld_i, pc_i                    EX-stage valid flag and PC
//   mtvec_i, mepc_i                   current CSR values
//   pipe_idle_i                       no outstanding memory/multicycle op
//   stall_o, flush_o                  pipeline freeze / kill
//   trap_o, trap_pc_o, trap_cause_o   CSR save strobe with mepc/mcause data
//   mret_o                            CSR restore strobe
//   jump_o, jump_pc_o                 fetch redirect strobe and target
//   drain_to_o                        sticky drain-timeout flag
//   busy_o                            sequencer not in IDLE
//
// drain_to_o is a sticky status flag. It stays visible in IDLE until reset;
// every other output is 0 in IDLE.
// -----------------------------------------------------------------------------
module trap_ctrl #(
  parameter int XLEN     = 64,
  parameter int DRAIN_TO = 16,
  parameter int CNT_W    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ext_irq_i,
  input  logic            sft_irq_i,
  input  logic            tmr_irq_i,
  input  logic            meie_i,
  input  logic            msie_i,
  input  logic            mtie_i,
  input  logic            glb_irq_i,
  input  logic            exp_vld_i,
  input  logic [3:0]      exp_code_i,
  input  logic            mret_i,
  input  logic            pc_vld_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            pipe_idle_i,
  output logic            stall_o,
  output logic            flush_o,
  output logic            trap_o,
  output logic [XLEN-1:0] trap_pc_o,
  output logic [XLEN-1:0] trap_cause_o,
  output logic            mret_o,
  output logic            jump_o,
  output logic [XLEN-1:0] jump_pc_o,
  output logic            drain_to_o,
  output logic            busy_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_TRAP  = 3'd2,
    S_JUMP  = 3'd3,
    S_RET   = 3'd4
  } state_t;

  // The counter holds the number of completed non-idle DRAIN cycles.
  // Timeout fires in the cycle that would make it reach DRAIN_TO.
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TO - 1);

  state_t             state_reg, state_next;
  logic [XLEN-1:0]    pc_reg;
  logic [XLEN-1:0]    cause_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               drain_to_reg;

  logic [2:0]         pend;
  logic [XLEN-1:0]    irq_cause;
  logic [XLEN-1:0]    exp_cause;
  logic               drain_last;
  logic [XLEN-1:0]    trap_base;
  logic [XLEN-1:0]    trap_target;

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  assign pend = {3{glb_irq_i}} & {ext_irq_i & meie_i,
                                  sft_irq_i & msie_i,
                                  tmr_irq_i & mtie_i};

  // Source priority is ext > sft > tmr. Interrupt causes carry the MSB.
  always_comb begin
    irq_cause = '0;
    irq_cause[XLEN-1] = 1'b1;
    if (pend[2])      irq_cause[3:0] = 4'd11;
    else if (pend[1]) irq_cause[3:0] = 4'd3;
    else              irq_cause[3:0] = 4'd7;
  end

  assign exp_cause  = {{(XLEN-4){1'b0}}, exp_code_i};
  assign drain_last = (cnt_reg == DRAIN_LAST);

  // ---------------------------------------------------------------------------
  // Trap target
  // ---------------------------------------------------------------------------
  assign trap_base = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  // Interrupt codes fit in 4 bits, so the vector offset is just code << 2.
  logic [XLEN-1:0] vec_off;
  assign vec_off     = {{(XLEN-6){1'b0}}, cause_reg[3:0], 2'b00};
  assign trap_target = (mtvec_i[1:0] == 2'b01 && cause_reg[XLEN-1])
                       ? trap_base + vec_off : trap_base;
`else
  // Mode bits have no meaning without vectoring.
  logic [1:0] unused_mtvec_mode;
  assign unused_mtvec_mode = mtvec_i[1:0];
  assign trap_target       = trap_base;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // Priority is exception > mret > interrupt. An event that loses is dropped.
  // A level interrupt is seen again the next time the block is in IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (pc_vld_i) begin
          if (exp_vld_i)      state_next = S_TRAP;
          else if (mret_i)    state_next = S_RET;
          else if (|pend)     state_next = S_DRAIN;
        end
      end
      S_DRAIN: if (pipe_idle_i || drain_last) state_next = S_TRAP;
      S_TRAP:  state_next = S_JUMP;
      S_JUMP:  state_next = S_IDLE;
      S_RET:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_o      = 1'b0;
    flush_o      = 1'b0;
    trap_o       = 1'b0;
    trap_pc_o    = '0;
    trap_cause_o = '0;
    mret_o       = 1'b0;
    jump_o       = 1'b0;
    jump_pc_o    = '0;
    unique case (state_reg)
      S_IDLE: ;
      S_DRAIN: stall_o = 1'b1;
      S_TRAP: begin
        stall_o      = 1'b1;
        flush_o      = 1'b1;
        trap_o       = 1'b1;
        trap_pc_o    = pc_reg;
        trap_cause_o = cause_reg;
      end
      S_JUMP: begin
        stall_o   = 1'b1;
        jump_o    = 1'b1;
        jump_pc_o = trap_target;
      end
      S_RET: begin
        flush_o   = 1'b1;
        mret_o    = 1'b1;
        jump_o    = 1'b1;
        jump_pc_o = mepc_i;
      end
      default: ;
    endcase
  end

  assign drain_to_o = drain_to_reg;
  assign busy_o     = (state_reg != S_IDLE);

  // ---------------------------------------------------------------------------
  // Latched trap context and drain counter
  // The interrupt is committed when the block enters DRAIN. Dropping the
  // request or its enable during DRAIN does not abort the sequence.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg       <= '0;
      cause_reg    <= '0;
      cnt_reg      <= '0;
      drain_to_reg <= 1'b0;
    end else begin
      if (state_reg == S_IDLE && pc_vld_i) begin
        if (exp_vld_i) begin
          pc_reg    <= pc_i;
          cause_reg <= exp_cause;
        end else if (!mret_i && (|pend)) begin
          pc_reg    <= pc_i;
          cause_reg <= irq_cause;
          cnt_reg   <= '0;
        end
      end
      if (state_reg == S_DRAIN && !pipe_idle_i) begin
        cnt_reg <= cnt_reg + 1'b1;
        if (drain_last) drain_to_reg <= 1'b1;
      end
    end
  end

endmodule
